// File: rtl/rss_bus_arbiter.sv
// Round-robin arbiter sharing the reservation-station result bus among execution
// units; each unit hands results into a one-entry slot, one broadcast per cycle.
module rss_bus_arbiter #(
  parameter  int NUM_REQ      = 3,
  parameter  int ROB_ID_WIDTH = 4,
  parameter  int XLEN         = 32,
  localparam int CNT_W        = $clog2(NUM_REQ + 1),
  localparam int PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rdy,
  input  logic                            reset_from_rob_bus,
  input  logic [NUM_REQ-1:0]              valid_from_units,
  input  logic [NUM_REQ*ROB_ID_WIDTH-1:0] dest_from_units,
  input  logic [NUM_REQ*XLEN-1:0]         value_from_units,
  input  logic [NUM_REQ*XLEN-1:0]         next_pc_from_units,
  output logic [NUM_REQ-1:0]              ready_to_units,
  output logic [ROB_ID_WIDTH-1:0]         dest_to_rss_bus,
  output logic [XLEN-1:0]                 value_to_rss_bus,
  output logic [XLEN-1:0]                 next_pc_to_rss_bus,
  output logic [CNT_W-1:0]                pending_count
);

  logic [NUM_REQ-1:0]      slot_full;
  logic [ROB_ID_WIDTH-1:0] slot_dest    [NUM_REQ];
  logic [XLEN-1:0]         slot_value   [NUM_REQ];
  logic [XLEN-1:0]         slot_next_pc [NUM_REQ];
  logic [PTR_W-1:0]        ptr;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] store;
  logic [NUM_REQ-1:0] full_next;
  logic [PTR_W-1:0]   winner;
  logic               any_grant;
  logic               any_reset;
  logic [CNT_W-1:0]   count_next;

  assign any_reset = rst || reset_from_rob_bus;

  // Scan from ptr upward (modulo NUM_REQ); the first occupied slot wins.
  always_comb begin : grant_scan
    int idx;
    // NOTE: every variable gets a default before the loop so no path leaves it unassigned and no latch is inferred.
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_grant && slot_full[idx]) begin
        grant[idx] = 1'b1;
        winner     = PTR_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

  // A slot being broadcast this cycle can be refilled on the same edge.
  assign ready_to_units = {NUM_REQ{rdy && !any_reset}} & (~slot_full | grant);
  assign accept         = valid_from_units & ready_to_units;

  always_comb begin
    store      = '0;
    full_next  = slot_full;
    count_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Id 0 means "no entry": the handshake completes but nothing is kept.
      store[i] = accept[i] && (dest_from_units[i*ROB_ID_WIDTH +: ROB_ID_WIDTH] != '0);
      if (store[i])      full_next[i] = 1'b1;
      else if (grant[i]) full_next[i] = 1'b0;
      count_next = count_next + CNT_W'(full_next[i]);
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (any_reset) begin
      // NOTE: only the occupancy flags are reset; slot payloads are don't-care while their flag is clear.
      slot_full          <= '0;
      ptr                <= '0;
      dest_to_rss_bus    <= '0;
      value_to_rss_bus   <= '0;
      next_pc_to_rss_bus <= '0;
      pending_count      <= '0;
    end else if (rdy) begin
      slot_full     <= full_next;
      pending_count <= count_next;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (store[i]) begin
          slot_dest[i]    <= dest_from_units[i*ROB_ID_WIDTH +: ROB_ID_WIDTH];
          slot_value[i]   <= value_from_units[i*XLEN +: XLEN];
          slot_next_pc[i] <= next_pc_from_units[i*XLEN +: XLEN];
        end
      end
      if (any_grant) begin
        dest_to_rss_bus    <= slot_dest[winner];
        value_to_rss_bus   <= slot_value[winner];
        next_pc_to_rss_bus <= slot_next_pc[winner];
        ptr                <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end else begin
        dest_to_rss_bus    <= '0;
        value_to_rss_bus   <= '0;
        next_pc_to_rss_bus <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rss_bus_arbiter.sv
// Scoreboard bench for rss_bus_arbiter: directed offers per unit, expected broadcasts
// queued up front and popped by an independent bus monitor.
module tb_rss_bus_arbiter;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] value;
    logic [31:0] next_pc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        reset_from_rob_bus = 1'b0;
  logic [2:0]  valid = '0;
  logic [11:0] dest_in = '0;
  logic [95:0] value_in = '0;
  logic [95:0] npc_in = '0;
  logic [2:0]  ready_to_units;
  logic [3:0]  dest_to_rss_bus;
  logic [31:0] value_to_rss_bus;
  logic [31:0] next_pc_to_rss_bus;
  logic [1:0]  pending_count;

  res_t offer_q [3][$];
  res_t exp_q [$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic upd = 1'b0;
  logic [2:0] seen;

  rss_bus_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
    .reset_from_rob_bus (reset_from_rob_bus),
    .valid_from_units   (valid),
    .dest_from_units    (dest_in),
    .value_from_units   (value_in),
    .next_pc_from_units (npc_in),
    .ready_to_units     (ready_to_units),
    .dest_to_rss_bus    (dest_to_rss_bus),
    .value_to_rss_bus   (value_to_rss_bus),
    .next_pc_to_rss_bus (next_pc_to_rss_bus),
    .pending_count      (pending_count)
  );

  always #5 clk = ~clk;

  function automatic res_t mk(input logic [3:0] d);
    res_t r;
    r.dest    = d;
    r.value   = 32'h1000_0000 + 32'(d);
    r.next_pc = 32'h0000_0100 + 32'(d) * 4;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs only change on an edge where rdy was high and no flush was applied.
  always @(posedge clk) upd <= rdy && !rst && !reset_from_rob_bus;

  // Monitor: every fresh non-zero broadcast must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (upd && dest_to_rss_bus != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_broadcast", 64'(dest_to_rss_bus), 64'h0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("bus_dest", 64'(dest_to_rss_bus), 64'(e.dest));
          check("bus_value", 64'(value_to_rss_bus), 64'(e.value));
          check("bus_next_pc", 64'(next_pc_to_rss_bus), 64'(e.next_pc));
        end
      end
    end
  end

  // One clock: present queue heads, sample ready before the edge, retire accepted offers.
  task automatic step(input logic flush, input logic en, output logic [2:0] rdy_seen);
    @(negedge clk);
    reset_from_rob_bus = flush;
    rdy = en;
    for (int i = 0; i < 3; i++) begin
      if (offer_q[i].size() > 0) begin
        valid[i]             = 1'b1;
        dest_in[i*4 +: 4]    = offer_q[i][0].dest;
        value_in[i*32 +: 32] = offer_q[i][0].value;
        npc_in[i*32 +: 32]   = offer_q[i][0].next_pc;
      end else begin
        valid[i]             = 1'b0;
        dest_in[i*4 +: 4]    = '0;
        value_in[i*32 +: 32] = '0;
        npc_in[i*32 +: 32]   = '0;
      end
    end
    #1 rdy_seen = ready_to_units;
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      if (valid[i] && rdy_seen[i]) void'(offer_q[i].pop_front());
    #1;
  endtask

  task automatic drain(input int n);
    logic [2:0] s;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, s);
  endtask

  task automatic do_reset();
    check("queue_empty_before_reset", 64'(exp_q.size()), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b1;
    reset_from_rob_bus = 1'b0;
    valid = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dest", 64'(dest_to_rss_bus), 64'h0);
    check("rst_value", 64'(value_to_rss_bus), 64'h0);
    check("rst_next_pc", 64'(next_pc_to_rss_bus), 64'h0);
    check("rst_pending", 64'(pending_count), 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset then idle.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b1, seen);
      check("idle_ready", 64'(seen), 64'h7);
      check("idle_dest", 64'(dest_to_rss_bus), 64'h0);
      check("idle_pending", 64'(pending_count), 64'h0);
    end

    // Single request from unit 1, two-edge latency, held one cycle.
    do_reset();
    offer_q[1].push_back('{dest: 4'd5, value: 32'h1234, next_pc: 32'h104});
    exp_q.push_back('{dest: 4'd5, value: 32'h1234, next_pc: 32'h104});
    step(1'b0, 1'b1, seen);
    check("single_ready", 64'(seen[1]), 64'h1);
    check("single_latency_dest", 64'(dest_to_rss_bus), 64'h0);
    check("single_pending_after_capture", 64'(pending_count), 64'h1);
    step(1'b0, 1'b1, seen);
    check("single_pending_after_bcast", 64'(pending_count), 64'h0);
    step(1'b0, 1'b1, seen);
    check("single_dest_cleared", 64'(dest_to_rss_bus), 64'h0);

    // Contention from ptr=0: broadcasts 1,2,3; pending 3,2,1,0.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      offer_q[i].push_back(mk(4'(i + 1)));
      exp_q.push_back(mk(4'(i + 1)));
    end
    step(1'b0, 1'b1, seen);
    check("contend_pending3", 64'(pending_count), 64'h3);
    step(1'b0, 1'b1, seen);
    check("contend_pending2", 64'(pending_count), 64'h2);
    step(1'b0, 1'b1, seen);
    check("contend_pending1", 64'(pending_count), 64'h1);
    step(1'b0, 1'b1, seen);
    check("contend_pending0", 64'(pending_count), 64'h0);
    drain(2);

    // Streaming from unit 0: back-to-back acceptance.
    do_reset();
    for (int d = 1; d <= 6; d++) begin
      offer_q[0].push_back(mk(4'(d)));
      exp_q.push_back(mk(4'(d)));
    end
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b1, seen);
      check("stream_ready0", 64'(seen[0]), 64'h1);
    end
    drain(2);

    // Fairness: units 0 and 2 continuously valid must alternate.
    do_reset();
    for (int d = 1; d <= 4; d++) begin
      offer_q[0].push_back(mk(4'(d)));
      offer_q[2].push_back(mk(4'(d + 8)));
    end
    for (int d = 1; d <= 4; d++) begin
      exp_q.push_back(mk(4'(d)));
      exp_q.push_back(mk(4'(d + 8)));
    end
    for (int c = 0; c < 9; c++) step(1'b0, 1'b1, seen);
    drain(2);

    // Dest 0 handshake completes but nothing is stored.
    do_reset();
    offer_q[1].push_back(mk(4'd0));
    step(1'b0, 1'b1, seen);
    check("dest0_ready", 64'(seen[1]), 64'h1);
    check("dest0_pending", 64'(pending_count), 64'h0);
    step(1'b0, 1'b1, seen);
    check("dest0_bus", 64'(dest_to_rss_bus), 64'h0);

    // Flush with two slots full while unit 2 offers dest 7.
    do_reset();
    offer_q[0].push_back(mk(4'd4));
    offer_q[1].push_back(mk(4'd5));
    step(1'b0, 1'b1, seen);
    check("flush_pending_before", 64'(pending_count), 64'h2);
    offer_q[2].push_back(mk(4'd7));
    step(1'b1, 1'b1, seen);
    check("flush_ready", 64'(seen), 64'h0);
    check("flush_dest", 64'(dest_to_rss_bus), 64'h0);
    check("flush_pending", 64'(pending_count), 64'h0);
    offer_q[2].delete();
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, seen);
      check("post_flush_dest", 64'(dest_to_rss_bus), 64'h0);
    end

    // rdy low freezes a non-zero broadcast.
    do_reset();
    for (int d = 1; d <= 3; d++) begin
      offer_q[0].push_back(mk(4'(d)));
      exp_q.push_back(mk(4'(d)));
    end
    step(1'b0, 1'b1, seen);
    step(1'b0, 1'b1, seen);
    check("freeze_first_dest", 64'(dest_to_rss_bus), 64'h1);
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b0, seen);
      check("freeze_ready", 64'(seen), 64'h0);
      check("freeze_dest", 64'(dest_to_rss_bus), 64'h1);
      check("freeze_value", 64'(value_to_rss_bus), 64'h1000_0001);
      check("freeze_pending", 64'(pending_count), 64'h1);
    end
    drain(4);
    check("freeze_final_dest", 64'(dest_to_rss_bus), 64'h0);

    check("queue_empty_at_end", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
